// File: rtl/rr_select_mux_pkg.sv
// Shared constants and the round-robin scan helper for the select stage.
package rr_select_mux_pkg;

  localparam int unsigned NUM_CH_DEFAULT     = 4;
  localparam int unsigned DATA_WIDTH_DEFAULT = 32;

  // Upper bound on channel count that rr_first can scan.
  localparam int unsigned MAX_CH    = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid scanning ptr, ptr+1, ... wrapping at num_ch (ptr < num_ch).
  function automatic rr_pick_t rr_first(input logic [MAX_CH-1:0] valid,
                                        input int unsigned       ptr,
                                        input int unsigned       num_ch);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      j = ptr + k;
      if (j >= num_ch) j = j - num_ch;
      if ((k < num_ch) && !res.found && valid[j[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_select_mux_pick.sv
// Combinational round-robin pick: rotate requests to start at ptr, find the first one,
// then map the relative position back to an absolute channel index.
module rr_priority_pick
  import rr_select_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEFAULT
) (
  input  logic [NUM_CH-1:0]         valid,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic                      found,
  output logic [$clog2(NUM_CH)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(NUM_CH);

  logic [2*NUM_CH-1:0] doubled;
  logic [NUM_CH-1:0]   rotated;
  rr_pick_t            pick;
  logic                unused_pick;

  // Rotate so bit 0 is channel ptr, leading-one detect, then add ptr back (natural wrap).
  always_comb begin
    doubled = {valid, valid};
    rotated = doubled[{1'b0, ptr} +: NUM_CH];
    pick    = rr_first(MAX_CH'(rotated), 0, NUM_CH);
    found   = pick.found;
    idx     = ptr + pick.idx[IdxW-1:0];
  end

  assign unused_pick = ^pick;

endmodule

// File: rtl/rr_select_mux.sv
// Registered N-channel select stage: round-robin (or fixed-priority) arbitration over
// valid/ready sources feeding a one-entry output register.
module rr_select_mux
  import rr_select_mux_pkg::*;
#(
  parameter int unsigned NUM_CH     = NUM_CH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_lock,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  input  logic                         out_ready
);

  localparam int unsigned IdxW = $clog2(NUM_CH);
  localparam logic [NUM_CH-1:0] OneHot0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IdxW-1:0]       out_ch_q, out_ch_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic                  lock_hold_q, lock_hold_d;

  logic                  can_load, xfer, found;
  logic [IdxW-1:0]       scan_ptr, grant_idx;
  logic [NUM_CH-1:0]     req, grant;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Request masking: a held lock restricts arbitration to the locked channel.
  always_comb begin
    scan_ptr = (FIXED_PRIO != 0) ? '0 : ptr_q;
    req      = in_valid;
    if (lock_hold_q) req = in_valid & (OneHot0 << ptr_q);
  end

  rr_priority_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .valid (req),
    .ptr   (scan_ptr),
    .found (found),
    .idx   (grant_idx)
  );

  // Handshake: accept only when the output register is empty or draining this cycle.
  always_comb begin
    can_load = ~out_valid_q | out_ready;
    grant    = found ? (OneHot0 << grant_idx) : '0;
    in_ready = (can_load && !reset) ? grant : '0;
    xfer     = found && can_load && !reset;
  end

  // Next state of the output register, pointer and lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    lock_hold_d = lock_hold_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      if (FIXED_PRIO == 0) begin
        if (in_lock[grant_idx]) begin
          ptr_d       = grant_idx;
          lock_hold_d = 1'b1;
        end else begin
          ptr_d       = grant_idx + IdxW'(1);
          lock_hold_d = 1'b0;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a held beat is dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
      lock_hold_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
      lock_hold_q <= lock_hold_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_select_mux.sv
// Scoreboard bench for rr_select_mux: round-robin instance checked through an expected-beat
// queue, fixed-priority instance checked directly.
module tb_rr_select_mux;

  localparam int unsigned NCh = 4;
  localparam int unsigned Dw  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCh-1:0]    in_valid;
  logic [NCh*Dw-1:0] in_data;
  logic [NCh-1:0]    in_lock;
  logic              out_ready;

  logic [NCh-1:0]    in_ready, fp_in_ready;
  logic              out_valid, fp_out_valid;
  logic [Dw-1:0]     out_data, fp_out_data;
  logic [1:0]        out_ch, fp_out_ch;

  typedef struct packed {
    logic [1:0]    ch;
    logic [Dw-1:0] data;
  } beat_t;

  beat_t sb_q[$];
  bit    sb_en = 1'b1;
  int    n_err = 0;
  int    n_chk = 0;

  always #5 clk = ~clk;

  rr_select_mux #(
    .NUM_CH     (NCh),
    .DATA_WIDTH (Dw),
    .FIXED_PRIO (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_lock   (in_lock),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  rr_select_mux #(
    .NUM_CH     (NCh),
    .DATA_WIDTH (Dw),
    .FIXED_PRIO (1)
  ) dut_fp (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_lock   (in_lock),
    .in_ready  (fp_in_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_ch    (fp_out_ch),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [Dw-1:0] d);
    in_data[ch*Dw +: Dw] = d;
  endtask

  function automatic void push(input int ch, input logic [Dw-1:0] d);
    sb_q.push_back({2'(ch), d});
  endfunction

  // Monitor: each beat the consumer takes must match the head of the queue.
  always @(negedge clk) begin
    beat_t e;
    if (sb_en && !reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_unexpected: got ch%0d data %h, expected no beat", out_ch, out_data);
      end else begin
        e = sb_q.pop_front();
        chk("sb_ch", 32'(out_ch), 32'(e.ch));
        chk("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; in_lock = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // 1: all valid, rotation 0,1,2,3,0
    for (int i = 0; i < 5; i++) push(i % 4, 16'h00A0 + 16'(i % 4));
    for (int i = 0; i < 4; i++) set_data(i, 16'h00A0 + 16'(i));
    in_valid = 4'b1111; reset = 1'b0;
    #1 chk("t1_in_ready", 32'(in_ready), 32'h1);
    repeat (5) tick();
    in_valid = '0;
    tick();
    chk("t1_drain_valid", 32'(out_valid), 32'd0);
    chk("t1_drain_data_hold", 32'(out_data), 32'h00A0);

    reset = 1'b1; tick(); reset = 1'b0;

    // 2: lone ch3 from ptr=0, then wrap to ch0
    push(3, 16'h00B3); push(0, 16'h00C0);
    in_valid = 4'b1000; set_data(3, 16'h00B3);
    #1 chk("t2_in_ready_ch3", 32'(in_ready), 32'h8);
    tick();
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 16'h00C0 + 16'(i));
    #1 chk("t2_in_ready_wrap", 32'(in_ready), 32'h1);
    tick();
    in_valid = '0; tick();

    // 3: stall with 0x1234 held, then drain and refill together
    push(1, 16'h1234); push(2, 16'h00D2); push(3, 16'h00D3); push(0, 16'h00D0);
    in_valid = 4'b0010; set_data(1, 16'h1234); out_ready = 1'b0;
    tick();
    in_valid = 4'b1101;
    set_data(0, 16'h00D0); set_data(2, 16'h00D2); set_data(3, 16'h00D3);
    #1 chk("t3_stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall_valid", 32'(out_valid), 32'd1);
      chk("t3_stall_data", 32'(out_data), 32'h1234);
      chk("t3_stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("t3_refill_in_ready", 32'(in_ready), 32'h4);
    repeat (3) tick();

    // 4: ch1 locked for two beats while ch2 waits
    push(1, 16'h00E1); push(1, 16'h00E4); push(1, 16'h00E7); push(2, 16'h00E2);
    in_valid = 4'b0110; set_data(1, 16'h00E1); set_data(2, 16'h00E2); in_lock = 4'b0010;
    #1 chk("t4_first_grant", 32'(in_ready), 32'h2);
    tick();
    set_data(1, 16'h00E4);
    #1 chk("t4_lock_grant", 32'(in_ready), 32'h2);
    tick();
    set_data(1, 16'h00E7); in_lock = '0;
    tick();
    in_valid = 4'b0100;
    #1 chk("t4_after_unlock", 32'(in_ready), 32'h4);
    tick();

    // 5: reset while a beat is held
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 16'h00F0 + 16'(i));
    tick();
    chk("t5_mid_valid", 32'(out_valid), 32'd1);
    chk("t5_mid_ch", 32'(out_ch), 32'd3);
    reset = 1'b1; out_ready = 1'b0;
    #1 chk("t5_in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    push(0, 16'h00F0);
    reset = 1'b0; out_ready = 1'b1;
    #1 chk("t5_first_grant", 32'(in_ready), 32'h1);
    tick();
    in_valid = '0; tick();

    // 6: fixed priority instance
    sb_en = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 16'h0C00 + 16'(i));
    #1 chk("t6_fp_in_ready", 32'(fp_in_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_fp_valid", 32'(fp_out_valid), 32'd1);
      chk("t6_fp_ch0", 32'(fp_out_ch), 32'd0);
      chk("t6_fp_data0", 32'(fp_out_data), 32'h0C00);
    end
    in_valid = 4'b1110;
    tick();
    chk("t6_fp_ch1", 32'(fp_out_ch), 32'd1);
    chk("t6_fp_data1", 32'(fp_out_data), 32'h0C01);
    in_valid = '0;
    tick();

    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
